// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: in-order store buffer that drains one entry per cycle,
// loads read memory combinationally and forward from the youngest matching buffered store.
module mem_access_stage #(
   parameter int SB_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_is_store,
   input  logic [7:0] req_base,
   input  logic [7:0] req_offset,
   input  logic [7:0] req_wdata,
   output logic       wb_valid,
   input  logic       wb_ready,
   output logic [7:0] wb_data,
   output logic [7:0] read_addr,
   input  logic [7:0] read_data,
   output logic [7:0] write_addr,
   output logic [7:0] write_data,
   output logic       mem_write,
   output logic       sb_empty
);

   localparam int DATA_W = 8;
   localparam int PW     = $clog2(SB_DEPTH);

   logic [DATA_W-1:0] r_sb_addr [SB_DEPTH];
   logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [PW:0]       r_count;
   logic              r_wb_valid;
   logic [DATA_W-1:0] r_wb_data;
   logic [DATA_W-1:0] r_raddr;
   logic [DATA_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   logic [DATA_W-1:0] w_ea;
   logic              w_full;
   logic              w_ready;
   logic              w_st_acc;
   logic              w_ld_acc;
   logic              w_pop;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;
   logic [PW-1:0]     w_fwd_idx;
   logic [DATA_W-1:0] w_ld_data;

   assign w_ea     = req_base + req_offset;
   assign w_full   = (r_count == (PW+1)'(SB_DEPTH));
   assign w_ready  = !w_full && (!r_wb_valid || wb_ready);
   assign w_st_acc = req_valid && w_ready && req_is_store;
   assign w_ld_acc = req_valid && w_ready && !req_is_store;
   assign w_pop    = (r_count != '0);

   // Scan oldest to youngest so the last match wins; the draining head is still a candidate.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_fwd_idx  = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         w_fwd_idx = r_head + PW'(i);
         if (((PW+1)'(i) < r_count) && (r_sb_addr[w_fwd_idx] == w_ea)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_sb_data[w_fwd_idx];
         end
      end
   end

   assign w_ld_data = w_fwd_hit ? w_fwd_data : read_data;

   assign req_ready  = w_ready;
   assign wb_valid   = r_wb_valid;
   assign wb_data    = r_wb_data;
   assign read_addr  = (rst_n && w_ld_acc) ? w_ea : r_raddr;
   assign mem_write  = w_pop;
   assign write_addr = w_pop ? r_sb_addr[r_head] : r_waddr;
   assign write_data = w_pop ? r_sb_data[r_head] : r_wdata;
   assign sb_empty   = (r_count == '0);

   always_ff @(posedge clk) begin
      if (w_st_acc) begin
         r_sb_addr[r_tail] <= w_ea;
         r_sb_data[r_tail] <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_wb_valid <= 1'b0;
         r_wb_data  <= '0;
         r_raddr    <= '0;
         r_waddr    <= '0;
         r_wdata    <= '0;
      end else begin
         if (w_st_acc) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head  <= r_head + 1'b1;
            r_waddr <= r_sb_addr[r_head];
            r_wdata <= r_sb_data[r_head];
         end
         case ({w_st_acc, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_ld_acc) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_ld_data;
            r_raddr    <= w_ea;
         end else if (wb_ready) begin
            r_wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic against an
// architectural memory model (stores update it at acceptance, loads read it).
module tb_mem_access_stage;

   localparam int SB_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_is_store;
   logic [7:0] req_base;
   logic [7:0] req_offset;
   logic [7:0] req_wdata;
   logic       wb_valid;
   logic       wb_ready;
   logic [7:0] wb_data;
   logic [7:0] read_addr;
   logic [7:0] read_data;
   logic [7:0] write_addr;
   logic [7:0] write_data;
   logic       mem_write;
   logic       sb_empty;

   mem_access_stage #(.SB_DEPTH(SB_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .read_addr(read_addr), .read_data(read_data),
      .write_addr(write_addr), .write_data(write_data),
      .mem_write(mem_write), .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   // Data memory seen by the DUT
   logic [7:0] env_mem [256];
   assign read_data = env_mem[read_addr];
   always @(posedge clk) if (mem_write === 1'b1) env_mem[write_addr] <= write_data;

   // Reference state
   logic [7:0]  ref_mem [256];
   logic [15:0] m_sb [$];
   logic        m_wbv;
   logic [7:0]  m_wbd;
   logic [7:0]  m_lwa;
   logic [7:0]  m_lwd;

   int nchecks = 0;
   int nerr    = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic st, input logic [7:0] base,
                       input logic [7:0] off, input logic [7:0] wd, input logic wbr);
      logic       exp_ready;
      logic       acc;
      logic [7:0] ea;
      logic [15:0] hd;
      req_valid    = v;
      req_is_store = st;
      req_base     = base;
      req_offset   = off;
      req_wdata    = wd;
      wb_ready     = wbr;
      ea = base + off;
      @(negedge clk);
      exp_ready = !(m_wbv && !wbr) && (m_sb.size() < SB_DEPTH);
      chk("req_ready", {7'b0, req_ready}, {7'b0, exp_ready});
      chk("sb_empty", {7'b0, sb_empty}, {7'b0, m_sb.size() == 0});
      if (m_sb.size() != 0) begin
         hd = m_sb[0];
         chk("mem_write", {7'b0, mem_write}, 8'h01);
         chk("write_addr", write_addr, hd[15:8]);
         chk("write_data", write_data, hd[7:0]);
      end else begin
         chk("mem_write_idle", {7'b0, mem_write}, 8'h00);
         chk("write_addr_hold", write_addr, m_lwa);
         chk("write_data_hold", write_data, m_lwd);
      end
      acc = v && exp_ready;
      if (acc && !st) chk("read_addr", read_addr, ea);
      @(posedge clk);
      if (m_sb.size() != 0) begin
         hd = m_sb.pop_front();
         m_lwa = hd[15:8];
         m_lwd = hd[7:0];
      end
      if (acc && st) begin
         ref_mem[ea] = wd;
         m_sb.push_back({ea, wd});
      end
      if (acc && !st) begin
         m_wbv = 1'b1;
         m_wbd = ref_mem[ea];
      end else if (wbr) begin
         m_wbv = 1'b0;
      end
      #1;
      chk("wb_valid", {7'b0, wb_valid}, {7'b0, m_wbv});
      chk("wb_data", wb_data, m_wbd);
   endtask

   task automatic reset_checks();
      chk("rst_mem_write", {7'b0, mem_write}, 8'h00);
      chk("rst_sb_empty", {7'b0, sb_empty}, 8'h01);
      chk("rst_wb_valid", {7'b0, wb_valid}, 8'h00);
      chk("rst_wb_data", wb_data, 8'h00);
      chk("rst_read_addr", read_addr, 8'h00);
      chk("rst_write_addr", write_addr, 8'h00);
      chk("rst_write_data", write_data, 8'h00);
   endtask

   // Asserts reset mid-cycle, checks the reset state, releases between edges.
   task automatic do_reset();
      req_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      reset_checks();
      @(posedge clk);
      #1;
      reset_checks();
      #2;
      rst_n = 1'b1;
      m_sb.delete();
      m_wbv = 1'b0;
      m_wbd = 8'h00;
      m_lwa = 8'h00;
      m_lwd = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[i] = env_mem[i];
   endtask

   initial begin
      for (int i = 0; i < 256; i++) env_mem[i] = 8'h09;
      rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
      req_base = 8'h00; req_offset = 8'h00; req_wdata = 8'h00; wb_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Address wrap: 0xF0 + 0x20 -> 0x10
      step(1, 1, 8'hF0, 8'h20, 8'h5A, 1);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);
      chk("wrap_mem_value", env_mem[8'h10], 8'h5A);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);

      // Forward from the head entry while it drains
      step(1, 1, 8'h40, 8'h00, 8'h33, 1);
      step(1, 0, 8'h30, 8'h10, 8'h00, 1);
      chk("fwd_0x40", wb_data, 8'h33);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);

      // Writeback backpressure
      step(1, 0, 8'h10, 8'h00, 8'h00, 0);
      step(1, 0, 8'h40, 8'h00, 8'h00, 0);
      step(0, 0, 8'h00, 8'h00, 8'h00, 0);
      chk("bp_hold", wb_data, 8'h5A);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);

      // Back-to-back stores never fill the buffer
      for (int i = 0; i <= SB_DEPTH; i++)
         step(1, 1, 8'hA0, 8'(i), 8'(8'hC0 + i), 1);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);

      // Youngest match
      step(1, 1, 8'h80, 8'h00, 8'h11, 1);
      step(1, 1, 8'h7F, 8'h01, 8'h22, 1);
      step(1, 0, 8'h80, 8'h00, 8'h00, 1);
      chk("youngest_0x80", wb_data, 8'h22);
      step(0, 0, 8'h00, 8'h00, 8'h00, 1);

      // Reset with a store still buffered
      step(1, 1, 8'h50, 8'h00, 8'hE1, 1);
      step(1, 1, 8'h51, 8'h00, 8'hE2, 1);
      step(1, 1, 8'h52, 8'h00, 8'hE3, 0);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 8'h00, 1);

      // Random traffic over a small address pool to provoke forwarding
      for (int n = 0; n < 400; n++) begin
         logic [7:0] b;
         case ($urandom_range(0, 2))
            0: b = 8'hF0;
            1: b = 8'h40;
            default: b = 8'h7E;
         endcase
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, b,
              8'($urandom_range(0, 3) * 8'h10), 8'($urandom_range(0, 255)),
              $urandom_range(0, 3) != 0);
         if (n == 200) begin
            do_reset();
            step(0, 0, 8'h00, 8'h00, 8'h00, 1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
